// File: rtl/led_pwm_bank.sv
// ---------------------------------------------------------------------------
// led_pwm_bank
//
// N-channel LED driver. Each channel can be OFF, ON, PWM, BLINK or BREATHE.
// Mode and duty are set through a simple one-cycle register-style write port.
// Runs entirely on clk_400_000. While the upstream MMCM is not locked, the
// timebase and LEDs are held idle, but configuration is kept.
//
// Ports
//   clk_400_000  in   1               sole clock
//   RESET        in   1               synchronous, active-high reset
//   locked       in   1               MMCM lock; low holds the bank idle
//   cfg_we       in   1               config write strobe (one cycle)
//   cfg_ch       in   $clog2(N_CH)+1  target channel index
//   cfg_mode     in   3               0 OFF, 1 ON, 2 PWM, 3 BLINK, 4 BREATHE,
//                                     5-7 behave as OFF
//   cfg_duty     in   PWM_W           PWM duty (applied at the next frame end)
//   cfg_err      out  1               one-cycle pulse after a write to a
//                                     channel index >= N_CH
//   led          out  N_CH            registered LED drive, bit i = channel i
// ---------------------------------------------------------------------------
module led_pwm_bank #(
    parameter int N_CH       = 8,
    parameter int PWM_W      = 8,
    parameter int PRESCALE   = 1562,
    parameter int FRAME_W    = 16,
    parameter int BLINK_BIT  = 8,
    parameter int RESET_MODE = 3
) (
    input  logic                    clk_400_000,
    input  logic                    RESET,
    input  logic                    locked,
    input  logic                    cfg_we,
    input  logic [$clog2(N_CH):0]   cfg_ch,
    input  logic [2:0]              cfg_mode,
    input  logic [PWM_W-1:0]        cfg_duty,
    output logic                    cfg_err,
    output logic [N_CH-1:0]         led
);

    localparam int CH_W    = $clog2(N_CH) + 1;
    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PWM_W-1:0]   MAX        = '1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [CH_W-1:0]    CH_LIMIT   = CH_W'(N_CH);

    localparam logic [2:0] MODE_ON      = 3'd1;
    localparam logic [2:0] MODE_PWM     = 3'd2;
    localparam logic [2:0] MODE_BLINK   = 3'd3;
    localparam logic [2:0] MODE_BREATHE = 3'd4;
    localparam logic [2:0] MODE_RESET   = 3'(RESET_MODE);

    // Timebase
    logic [PRESC_W-1:0] presc;
    logic [PWM_W-1:0]   pwm_cnt;
    logic [FRAME_W-1:0] frame_cnt;

    // Per-channel configuration and breathe state
    logic [2:0]       mode   [N_CH];
    logic [PWM_W-1:0] duty   [N_CH];
    logic [PWM_W-1:0] shadow [N_CH];
    logic [PWM_W-1:0] ramp   [N_CH];
    logic             down   [N_CH];

    logic             tick;
    logic             frame_end;
    logic             wr_ok;
    logic             wr_bad;
    logic [N_CH-1:0]  wr_hit;
    logic [N_CH-1:0]  led_next;
    logic [PWM_W-1:0] ramp_next [N_CH];
    logic             down_next [N_CH];

    // Timebase strobes and write decode. Out-of-range writes are flagged
    // but never decoded onto a channel.
    always_comb begin
        tick      = (presc == PRESC_LAST);
        frame_end = tick && (pwm_cnt == MAX);
        wr_ok     = cfg_we && locked && (cfg_ch < CH_LIMIT);
        wr_bad    = cfg_we && locked && !(cfg_ch < CH_LIMIT);
        for (int i = 0; i < N_CH; i++) begin
            wr_hit[i] = wr_ok && (cfg_ch == CH_W'(i));
        end
    end

    // LED function per channel, evaluated on the current counters. With a
    // strict compare, duty=MAX gives MAX high steps out of MAX+1.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            case (mode[i])
                MODE_ON:      led_next[i] = 1'b1;
                MODE_PWM:     led_next[i] = (pwm_cnt < duty[i]);
                MODE_BLINK:   led_next[i] = frame_cnt[BLINK_BIT];
                MODE_BREATHE: led_next[i] = (pwm_cnt < ramp[i]);
                default:      led_next[i] = 1'b0;
            endcase
        end
    end

    // Breathe triangle: bounce off MAX and 0 so both endpoints last a single
    // frame, giving a period of 2*MAX frames. A fresh BREATHE write restarts
    // the ramp and takes priority over the frame-end step.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ramp_next[i] = ramp[i];
            down_next[i] = down[i];
            if (frame_end && (mode[i] == MODE_BREATHE)) begin
                if (!down[i]) begin
                    if (ramp[i] == MAX) begin
                        down_next[i] = 1'b1;
                        ramp_next[i] = MAX - 1'b1;
                    end else begin
                        ramp_next[i] = ramp[i] + 1'b1;
                    end
                end else begin
                    if (ramp[i] == '0) begin
                        down_next[i] = 1'b0;
                        ramp_next[i] = PWM_W'(1);
                    end else begin
                        ramp_next[i] = ramp[i] - 1'b1;
                    end
                end
            end
            if (wr_hit[i] && (cfg_mode == MODE_BREATHE)) begin
                ramp_next[i] = '0;
                down_next[i] = 1'b0;
            end
        end
    end

    // State update. Loss of lock parks the timebase and breathe state at
    // their start values so the bank restarts cleanly from pwm_cnt=0.
    // Active duty only changes on a frame end to avoid PWM glitches; a write
    // landing exactly on that frame end is taken directly.
    always_ff @(posedge clk_400_000) begin
        if (RESET) begin
            presc     <= '0;
            pwm_cnt   <= '0;
            frame_cnt <= '0;
            led       <= '0;
            cfg_err   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                mode[i]   <= MODE_RESET;
                duty[i]   <= '0;
                shadow[i] <= '0;
                ramp[i]   <= '0;
                down[i]   <= 1'b0;
            end
        end else if (!locked) begin
            presc     <= '0;
            pwm_cnt   <= '0;
            frame_cnt <= '0;
            led       <= '0;
            cfg_err   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                ramp[i] <= '0;
                down[i] <= 1'b0;
            end
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (frame_end) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            led     <= led_next;
            cfg_err <= wr_bad;
            for (int i = 0; i < N_CH; i++) begin
                if (wr_hit[i]) begin
                    mode[i]   <= cfg_mode;
                    shadow[i] <= cfg_duty;
                end
                if (frame_end) begin
                    duty[i] <= wr_hit[i] ? cfg_duty : shadow[i];
                end
                ramp[i] <= ramp_next[i];
                down[i] <= down_next[i];
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_bank.sv
// ---------------------------------------------------------------------------
// tb_led_pwm_bank
//
// Bench for led_pwm_bank with N_CH=4, PWM_W=4, PRESCALE=2, FRAME_W=8,
// BLINK_BIT=1, RESET_MODE=3. A reference process queues the expected
// {led, cfg_err} after every clock; a monitor pops and compares them on the
// falling edge. Directed tasks add hand-computed high-cycle counts.
// ---------------------------------------------------------------------------
module tb_led_pwm_bank;

    logic       clk;
    logic       rst;
    logic       locked;
    logic       cfg_we;
    logic [2:0] cfg_ch;
    logic [2:0] cfg_mode;
    logic [3:0] cfg_duty;
    logic       cfg_err;
    logic [3:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: counters are derived from cycles since (re)start
    logic [4:0] exp_q [$];
    int         m_t;
    logic [2:0] m_mode   [4];
    logic [3:0] m_duty   [4];
    logic [3:0] m_shadow [4];
    int         m_bf     [4];

    led_pwm_bank #(
        .N_CH(4), .PWM_W(4), .PRESCALE(2), .FRAME_W(8),
        .BLINK_BIT(1), .RESET_MODE(3)
    ) dut (
        .clk_400_000(clk),
        .RESET(rst),
        .locked(locked),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode),
        .cfg_duty(cfg_duty),
        .cfg_err(cfg_err),
        .led(led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Triangle 0..15..1 with period 30 frames
    function automatic int tri_wave(input int k);
        return (k <= 15) ? k : 30 - k;
    endfunction

    function automatic logic [3:0] model_led();
        logic [3:0] v;
        int pwm;
        int frame;
        pwm   = (m_t / 2) % 16;
        frame = (m_t / 32) % 256;
        for (int i = 0; i < 4; i++) begin
            case (m_mode[i])
                3'd1:    v[i] = 1'b1;
                3'd2:    v[i] = (pwm < int'(m_duty[i]));
                3'd3:    v[i] = (((frame >> 1) & 1) == 1);
                3'd4:    v[i] = (pwm < tri_wave(m_bf[i] % 30));
                default: v[i] = 1'b0;
            endcase
        end
        return v;
    endfunction

    // Reference model: push the expected output for this edge, then advance
    initial begin
        bit fe;
        bit hit;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_t = 0;
                for (int i = 0; i < 4; i++) begin
                    m_mode[i]   = 3'd3;
                    m_duty[i]   = 4'd0;
                    m_shadow[i] = 4'd0;
                    m_bf[i]     = 0;
                end
                exp_q.push_back(5'b0);
            end else if (!locked) begin
                m_t = 0;
                for (int i = 0; i < 4; i++) m_bf[i] = 0;
                exp_q.push_back(5'b0);
            end else begin
                exp_q.push_back({model_led(), (cfg_we && (cfg_ch >= 3'd4))});
                fe = ((m_t % 32) == 31);
                for (int i = 0; i < 4; i++) begin
                    hit = cfg_we && (cfg_ch == 3'(i));
                    if (fe) m_duty[i] = hit ? cfg_duty : m_shadow[i];
                    if (hit && (cfg_mode == 3'd4)) m_bf[i] = 0;
                    else if (fe && (m_mode[i] == 3'd4)) m_bf[i] = m_bf[i] + 1;
                    if (hit) begin
                        m_mode[i]   = cfg_mode;
                        m_shadow[i] = cfg_duty;
                    end
                end
                m_t = m_t + 1;
            end
        end
    end

    // Monitor: every edge presents a new registered output
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({led, cfg_err} !== e) begin
                    n_fail++;
                    $display("[TB] FAIL led_err @%0t: actual led=%b cfg_err=%b, required led=%b cfg_err=%b",
                             $time, led, cfg_err, e[4:1], e[0]);
                end
            end
        end
    end

    // Absolute bound so the run can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int ch, input int mode, input int duty);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_ch   = 3'(ch);
        cfg_mode = 3'(mode);
        cfg_duty = 4'(duty);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_high(input int ch, input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (led[ch] === 1'b1) c++;
        end
    endtask

    initial begin
        int c;
        bit found;
        rst      = 1'b1;
        locked   = 1'b1;
        cfg_we   = 1'b0;
        cfg_ch   = 3'd0;
        cfg_mode = 3'd0;
        cfg_duty = 4'd0;
        wait_cycles(3);
        rst = 1'b0;

        // BLINK after reset: 50 % duty with a 128-cycle period
        wait_cycles(150);
        count_high(0, 128, c);
        check_output("blink_ch0_count", c, 64);
        count_high(3, 128, c);
        check_output("blink_ch3_count", c, 64);

        // PWM duty 5: 5 ticks of 2 cycles in every 32-cycle frame
        apply_stimulus(0, 2, 5);
        wait_cycles(40);
        count_high(0, 32, c);
        check_output("pwm_duty5_count", c, 10);

        // BREATHE: one 30-frame period holds sum(ramp)*2 = 225*2 high cycles
        apply_stimulus(1, 4, 0);
        count_high(1, 960, c);
        check_output("breathe_period_count", c, 450);

        // Out-of-range channel writes
        apply_stimulus(4, 1, 3);
        apply_stimulus(7, 0, 0);
        wait_cycles(5);

        // Lose lock mid-frame; a write during unlock must be ignored
        @(negedge clk);
        locked = 1'b0;
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_ch   = 3'd0;
        cfg_mode = 3'd1;
        cfg_duty = 4'd15;
        @(negedge clk);
        cfg_we = 1'b0;
        wait_cycles(7);
        check_output("unlock_led_zero", int'(led), 0);
        @(negedge clk);
        locked = 1'b1;
        wait_cycles(3);
        count_high(0, 32, c);
        check_output("relock_pwm_count", c, 10);

        // Duty 0 keeps the channel dark once the frame boundary passes
        apply_stimulus(0, 2, 0);
        wait_cycles(40);
        count_high(0, 32, c);
        check_output("pwm_duty0_count", c, 0);

        // Write landing exactly on frame end takes effect in the next frame
        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            @(negedge clk);
            if ((m_t % 32) == 31) found = 1'b1;
        end
        check_output("frame_end_found", int'(found), 1);
        cfg_we   = 1'b1;
        cfg_ch   = 3'd2;
        cfg_mode = 3'd2;
        cfg_duty = 4'd9;
        @(negedge clk);
        cfg_we = 1'b0;
        count_high(2, 32, c);
        check_output("frame_end_direct_duty", c, 18);

        // Reset wins over a same-cycle write
        @(negedge clk);
        rst      = 1'b1;
        cfg_we   = 1'b1;
        cfg_ch   = 3'd3;
        cfg_mode = 3'd1;
        cfg_duty = 4'd7;
        @(negedge clk);
        check_output("reset_led_zero", int'(led), 0);
        rst    = 1'b0;
        cfg_we = 1'b0;
        count_high(3, 32, c);
        check_output("reset_write_lost", c, 0);

        @(negedge clk);
        check_output("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
